// File: rtl/fib_pkg.sv
// Shared constants for the fibonacci RAM writer: FSM state encoding and sequence seeds.
package fib_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int FIB_SEED0 = 0;
   localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_next_term.sv
// Combinational next-term adder: m-bit sum of two terms plus a sticky "true value
// exceeds m bits" flag that propagates from either operand or from the carry.
module fib_next_term #(
   parameter int m = 8
) (
   input  logic [m-1:0] a,
   input  logic [m-1:0] b,
   input  logic         ca,
   input  logic         cb,
   output logic [m-1:0] sum,
   output logic         cout_flag
);

   logic carry;

   always_comb begin
      {carry, sum} = {1'b0, a} + {1'b0, b};
      cout_flag    = ca | cb | carry;
   end

endmodule

// File: rtl/fib_ram_writer.sv
// Fibonacci write-side master for a single-port RAM: one term per clock from address 0.
// Optional macro FIB_OVF_STOP_EN: stop before the first term that no longer fits in m bits.
module fib_ram_writer #(
   parameter int n = 6,
   parameter int m = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [n:0]   num_terms,
   output logic [n-1:0] addr,
   output logic [m-1:0] data_in,
   output logic         we,
   output logic         busy,
   output logic         done,
   output logic         ovf
);

   import fib_pkg::*;

   localparam logic [n:0] DEPTH = {1'b1, {n{1'b0}}};
   localparam logic [n:0] ONE   = {{n{1'b0}}, 1'b1};

   logic [1:0]   state;
   logic [m-1:0] a, b;
   logic         ca, cb;
   logic [n:0]   idx, lim;
   logic [n:0]   idx_next;
   logic [n:0]   num_lim;
   logic [m-1:0] sum;
   logic         cout_flag;
   logic         stop_now;

   fib_next_term #(.m(m)) u_next (
      .a         (a),
      .b         (b),
      .ca        (ca),
      .cb        (cb),
      .sum       (sum),
      .cout_flag (cout_flag)
   );

   assign idx_next = idx + ONE;
   assign num_lim  = (num_terms > DEPTH) ? DEPTH : num_terms;

`ifdef FIB_OVF_STOP_EN
   // Refuse to write a term whose true value no longer fits, so the RAM holds exact terms only.
   assign stop_now = ca;
`else
   assign stop_now = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state   <= ST_IDLE;
         a       <= '0;
         b       <= '0;
         ca      <= 1'b0;
         cb      <= 1'b0;
         idx     <= '0;
         lim     <= '0;
         addr    <= '0;
         data_in <= '0;
         we      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         // NOTE: we/done default low each cycle so they are true one-cycle strobes, not held values.
         we   <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ovf <= 1'b0;
                  if (num_terms == '0) begin
                     state <= ST_DONE;
                  end else begin
                     lim   <= num_lim;
                     a     <= m'(FIB_SEED0);
                     b     <= m'(FIB_SEED1);
                     ca    <= 1'b0;
                     cb    <= 1'b0;
                     idx   <= '0;
                     state <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               busy <= 1'b1;
               if (stop_now) begin
                  ovf   <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  we      <= 1'b1;
                  addr    <= idx[n-1:0];
                  data_in <= a;
                  if (ca) ovf <= 1'b1;
                  a   <= b;
                  ca  <= cb;
                  b   <= sum;
                  cb  <= cout_flag;
                  idx <= idx_next;
                  if (idx_next == lim) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_ram_writer.sv
// Directed bench for fib_ram_writer with an attached RAM model; each run's memory is read back.
module tb_fib_ram_writer;

   localparam int N = 6;
   localparam int M = 8;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [N:0]   num_terms;
   logic [N-1:0] addr;
   logic [M-1:0] data_in;
   logic         we, busy, done, ovf;

   fib_ram_writer #(.n(N), .m(M)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .num_terms (num_terms),
      .addr      (addr),
      .data_in   (data_in),
      .we        (we),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // RAM model; wr_run tags each location with the run that last wrote it
   logic [M-1:0] mem [64];
   int           wr_run [64];
   int           cur_run = 0;
   int           total_writes = 0;

   always @(posedge clk) begin
      if (we) begin
         mem[addr]    <= data_in;
         wr_run[addr] <= cur_run;
         total_writes <= total_writes + 1;
      end
   end

   int n_vec = 0;
   int n_bad = 0;
   int fib_mod [64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run(input int nt, input int repulse_addr,
                      output int writes, output int done_at, output int first_addr,
                      output int last_addr, output logic busy_seen, output logic ovf_at_done);
      cur_run++;
      @(negedge clk);
      num_terms = nt[N:0];
      start     = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      writes      = 0;
      done_at     = -1;
      first_addr  = -1;
      last_addr   = -1;
      busy_seen   = 1'b0;
      ovf_at_done = 1'b0;
      for (int j = 1; j <= 200 && done_at < 0; j++) begin
         @(negedge clk);
         if (we) begin
            writes++;
            if (first_addr < 0) first_addr = int'(addr);
            last_addr = int'(addr);
         end
         if (busy) busy_seen = 1'b1;
         if (done) begin
            done_at     = j;
            ovf_at_done = ovf;
         end
         start = we && (int'(addr) == repulse_addr);
      end
      start = 1'b0;
   endtask

   // Compare RAM contents of the current run against the reference sequence.
   task automatic check_mem(input int writes);
      for (int i = 0; i < writes; i++) begin
         check($sformatf("mem_written[%0d]", i), 32'(wr_run[i] == cur_run), 1);
         check($sformatf("mem_data[%0d]", i), 32'(mem[i]), fib_mod[i]);
      end
      if (writes < 64)
         check($sformatf("mem_untouched[%0d]", writes), 32'(wr_run[writes] == cur_run), 0);
   endtask

   typedef struct {
      int   nt;
      int   writes;
      int   done_at;
      logic ovf;
      int   last;
      int   chk_addr;
      int   chk_data;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   w, d, fa, la;
      logic bs, od;
      int   cnt;

      fib_mod[0] = 0;
      fib_mod[1] = 1;
      for (int i = 2; i < 64; i++) fib_mod[i] = (fib_mod[i-1] + fib_mod[i-2]) % 256;

      vecs[0] = '{10, 10, 11, 1'b0, 9, 9, 34};
`ifdef FIB_OVF_STOP_EN
      vecs[1] = '{16, 14, 16, 1'b1, 13, 13, 233};
`else
      vecs[1] = '{16, 16, 17, 1'b1, 15, 15, 98};
`endif
      vecs[2] = '{0, 0, 1, 1'b0, -1, -1, 0};
      vecs[3] = '{1, 1, 2, 1'b0, 0, 0, 0};
      vecs[4] = '{13, 13, 14, 1'b0, 12, 12, 144};
`ifdef FIB_OVF_STOP_EN
      vecs[5] = '{15, 14, 16, 1'b1, 13, 7, 13};
      vecs[6] = '{100, 14, 16, 1'b1, 13, 13, 233};
      vecs[7] = '{64, 14, 16, 1'b1, 13, 2, 1};
`else
      vecs[5] = '{15, 15, 16, 1'b1, 14, 14, 121};
      vecs[6] = '{100, 64, 65, 1'b1, 63, 20, 109};
      vecs[7] = '{64, 64, 65, 1'b1, 63, 2, 1};
`endif
      vecs[8] = '{2, 2, 3, 1'b0, 1, 1, 1};

      // Reset for two cycles from power-up
      reset     = 1'b1;
      start     = 1'b0;
      num_terms = '0;
      repeat (2) @(negedge clk);
      check("rst_addr", 32'(addr), 0);
      check("rst_data_in", 32'(data_in), 0);
      check("rst_we", 32'(we), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ovf", 32'(ovf), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_no_writes", 32'(total_writes), 0);

      foreach (vecs[v]) begin
         run(vecs[v].nt, -1, w, d, fa, la, bs, od);
         check($sformatf("v%0d_writes", v), 32'(w), vecs[v].writes);
         check($sformatf("v%0d_done_cycle", v), 32'(d), vecs[v].done_at);
         check($sformatf("v%0d_ovf", v), 32'(od), 32'(vecs[v].ovf));
         check($sformatf("v%0d_last_addr", v), 32'(la), vecs[v].last);
         check($sformatf("v%0d_first_addr", v), 32'(fa), (vecs[v].writes > 0) ? 0 : -1);
         check($sformatf("v%0d_busy_seen", v), 32'(bs), 32'(vecs[v].nt > 0));
         if (vecs[v].chk_addr >= 0)
            check($sformatf("v%0d_word", v), 32'(mem[vecs[v].chk_addr]), vecs[v].chk_data);
         check_mem(w);
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", v), 32'(done), 0);
         check($sformatf("v%0d_ovf_sticky", v), 32'(ovf), 32'(vecs[v].ovf));
      end

      // Reset while idle clears the sticky overflow flag
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_rst_ovf", 32'(ovf), 0);
      check("idle_rst_addr", 32'(addr), 0);
      check("idle_rst_data_in", 32'(data_in), 0);
      reset = 1'b0;
      @(negedge clk);

      // start re-pulsed while writing address 3 is ignored
      run(10, 3, w, d, fa, la, bs, od);
      check("repulse_writes", 32'(w), 10);
      check("repulse_done_cycle", 32'(d), 11);
      check("repulse_last_addr", 32'(la), 9);
      check_mem(w);
      repeat (4) @(negedge clk);
      check("repulse_not_queued", 32'(busy | we), 0);

      // Reset while address 5 is on the bus abandons the run
      cur_run++;
      @(negedge clk);
      num_terms = 7'd10;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt   = 0;
      while (!(we && addr == 6'd5) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("midrun_reached_addr5", 32'(we && addr == 6'd5), 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrun_rst_we", 32'(we), 0);
      check("midrun_rst_busy", 32'(busy), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midrun_addr5_written", 32'(wr_run[5] == cur_run), 1);
      check("midrun_addr6_untouched", 32'(wr_run[6] == cur_run), 0);
      check("midrun_idle_we", 32'(we), 0);

      run(3, -1, w, d, fa, la, bs, od);
      check("restart_first_addr", 32'(fa), 0);
      check("restart_writes", 32'(w), 3);
      check("restart_done_cycle", 32'(d), 4);
      check_mem(w);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
